// File: rtl/an_encoder_n37_pkg.sv
// Shared constants, Barrett reduction constants and FSM state type for the AN-code (A = 37) encoder.
package an_code_pkg;

  localparam int unsigned A      = 37;
  localparam int unsigned A_W    = 6;
  localparam int unsigned DATA_W = 13;
  localparam int unsigned CW_W   = 18;
  localparam int unsigned IDX_W  = $clog2(A_W);

  // Largest data word whose product with A still fits in CW_W bits (7084).
  localparam int unsigned MAX_DATA = ((1 << CW_W) - 1) / A;

  // Barrett reduction: q ~= (x * BARRETT_MULT) >> BARRETT_SHIFT, off by at most one.
  localparam int unsigned BARRETT_SHIFT = 19;
  localparam int unsigned BARRETT_MULT  = (1 << BARRETT_SHIFT) / A;
  localparam int unsigned BARRETT_MW    = 14;

  localparam logic [A_W-1:0]    A_VEC        = A_W'(A);
  localparam logic [DATA_W-1:0] MAX_DATA_VEC = DATA_W'(MAX_DATA);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/an_encoder_n37_if.sv
// Source/sink handshake bundle of the AN encoder; slave is the encoder side.
interface an_encoder_n37_if;
  import an_code_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   codeword;
  logic              ovf;
  logic              chk_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, codeword, ovf, chk_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, codeword, ovf, chk_err
  );

endinterface

// File: rtl/an_encoder_n37_residue_chk.sv
// Combinational codeword mod A via Barrett reduction with a single correction step.
module an_residue_chk
  import an_code_pkg::*;
(
  input  logic [CW_W-1:0] codeword,
  output logic [A_W-1:0]  residue
);

  localparam int unsigned PROD_W = CW_W + BARRETT_MW;
  localparam int unsigned Q_W    = PROD_W - BARRETT_SHIFT;

  logic [PROD_W-1:0] prod;
  logic [Q_W-1:0]    quot;
  logic [CW_W-1:0]   q_times_a;
  logic [CW_W-1:0]   rem_raw;

  assign prod      = PROD_W'(codeword) * PROD_W'(BARRETT_MULT);
  assign quot      = prod[PROD_W-1:BARRETT_SHIFT];
  assign q_times_a = CW_W'(quot) * CW_W'(A);
  assign rem_raw   = codeword - q_times_a;

  // The truncated multiplier underestimates the quotient by at most one.
  assign residue = (rem_raw >= CW_W'(A)) ? A_W'(rem_raw - CW_W'(A)) : A_W'(rem_raw);

endmodule

// File: rtl/an_encoder_n37.sv
// Multi-cycle AN encoder: codeword = data * 37 by shift-add, one bit of A per cycle.
// Optional residue self-check enabled with AN_ENC_SELFCHECK_EN.
module an_encoder_n37
  import an_code_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  an_encoder_n37_if.slave  bus
);

  state_t           state_reg, state_next;
  logic [CW_W-1:0]  acc_reg, acc_next;
  logic [CW_W-1:0]  operand_reg, operand_next;
  logic [IDX_W-1:0] bit_idx_reg, bit_idx_next;
  logic             ovf_reg, ovf_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      operand_reg <= '0;
      bit_idx_reg <= '0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      operand_reg <= operand_next;
      bit_idx_reg <= bit_idx_next;
      ovf_reg     <= ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    operand_next = operand_reg;
    bit_idx_next = bit_idx_reg;
    ovf_next     = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          operand_next = CW_W'(bus.in_data);
          acc_next     = '0;
          bit_idx_next = '0;
          ovf_next     = (bus.in_data > MAX_DATA_VEC);
          state_next   = ACC;
        end
      end
      ACC: begin
        // An out-of-range word spends exactly one cycle here, giving the fixed 1-cycle overflow latency.
        if (ovf_reg) begin
          acc_next   = '0;
          state_next = DONE;
        end else begin
          if (A_VEC[bit_idx_reg]) begin
            acc_next = acc_reg + (operand_reg << bit_idx_reg);
          end
          if (bit_idx_reg == IDX_W'(A_W - 1)) begin
            state_next = DONE;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.codeword  = acc_reg;
  assign bus.ovf       = ovf_reg;

`ifdef AN_ENC_SELFCHECK_EN
  logic [A_W-1:0] residue;
  logic           chk_err_reg, chk_err_next;

  // Checking acc_next lets the flag become valid on the same edge as out_valid.
  an_residue_chk u_residue_chk (
    .codeword (acc_next),
    .residue  (residue)
  );

  always_comb begin
    chk_err_next = 1'b0;
    if (state_next == DONE) begin
      if (state_reg != DONE) begin
        chk_err_next = (residue != '0) && !ovf_next;
      end else begin
        chk_err_next = chk_err_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_reg <= 1'b0;
    end else begin
      chk_err_reg <= chk_err_next;
    end
  end

  assign bus.chk_err = chk_err_reg;
`else
  assign bus.chk_err = 1'b0;
`endif

endmodule
